// File: rtl/tensor_job_arbiter.sv
// tensor_job_arbiter: shares one TensorUnit between two requesters.
// Round-robin grant, latches the winning job, drives the TensorUnit
// handshake, captures the last result beat and returns it tagged with
// the requester ID. Optional watchdog enabled by TENSOR_ARB_TIMEOUT_EN.
module tensor_job_arbiter #(
  parameter int D_WIDTH        = 32,
  parameter int M_SIZE         = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                                aclk,
  input  logic                                areset,
  input  logic [1:0]                          i_req_valid,
  output logic [1:0]                          o_req_ready,
  input  logic [D_WIDTH*M_SIZE*M_SIZE-1:0]    i_req0_matrix,
  input  logic [D_WIDTH*M_SIZE*M_SIZE-1:0]    i_req1_matrix,
  input  logic [D_WIDTH*M_SIZE-1:0]           i_req0_vector,
  input  logic [D_WIDTH*M_SIZE-1:0]           i_req1_vector,
  output logic [D_WIDTH*M_SIZE*M_SIZE-1:0]    o_tu_matrix,
  output logic [D_WIDTH*M_SIZE-1:0]           o_tu_vector,
  output logic                                o_tu_matrix_is_valid,
  output logic                                o_tu_vector_is_valid,
  input  logic                                i_tu_ready_to_accept_matrix,
  input  logic                                i_tu_ready_to_accept_vector,
  output logic                                o_tu_receiver_ready_for_result,
  input  logic                                i_tu_result_is_valid,
  input  logic                                i_tu_this_is_the_last_result,
  input  logic [D_WIDTH*M_SIZE-1:0]           i_tu_result,
  output logic [D_WIDTH*M_SIZE-1:0]           o_result,
  output logic                                o_result_id,
  output logic                                o_result_error,
  output logic                                o_result_valid,
  input  logic                                i_result_ready,
  output logic                                o_busy
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_RESULT,
    DELIVER
  } state_t;

  state_t     state;
  logic       ptr;
  logic       other;
  logic       job_id;
  logic [1:0] grant;
  logic       accept;
  logic       win_id;

`ifdef TENSOR_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] wait_cnt;
`else
  assign o_result_error = 1'b0;
`endif

  assign other       = ~ptr;
  assign o_req_ready = grant;
  assign accept      = |grant;
  assign win_id      = grant[1];

  // One-hot grant while idle: the pointer requester wins if valid, else the other one.
  always_comb begin
    grant = 2'b00;
    if (state == IDLE && !areset) begin
      if (i_req_valid[ptr]) begin
        grant[ptr] = 1'b1;
      end else if (i_req_valid[other]) begin
        grant[other] = 1'b1;
      end
    end
  end

  // Job FSM with registered outputs; a reset drops any job in flight.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state                          <= IDLE;
      ptr                            <= 1'b0;
      job_id                         <= 1'b0;
      o_tu_matrix                    <= '0;
      o_tu_vector                    <= '0;
      o_tu_matrix_is_valid           <= 1'b0;
      o_tu_vector_is_valid           <= 1'b0;
      o_tu_receiver_ready_for_result <= 1'b0;
      o_result                       <= '0;
      o_result_id                    <= 1'b0;
      o_result_valid                 <= 1'b0;
      o_busy                         <= 1'b0;
`ifdef TENSOR_ARB_TIMEOUT_EN
      o_result_error                 <= 1'b0;
      wait_cnt                       <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            o_tu_matrix          <= win_id ? i_req1_matrix : i_req0_matrix;
            o_tu_vector          <= win_id ? i_req1_vector : i_req0_vector;
            job_id               <= win_id;
            ptr                  <= ~win_id;
            o_tu_matrix_is_valid <= 1'b1;
            o_tu_vector_is_valid <= 1'b1;
            o_busy               <= 1'b1;
            state                <= ISSUE;
`ifdef TENSOR_ARB_TIMEOUT_EN
            o_result_error       <= 1'b0;
`endif
          end
        end
        ISSUE: begin
          if (i_tu_ready_to_accept_matrix && i_tu_ready_to_accept_vector) begin
            o_tu_matrix_is_valid           <= 1'b0;
            o_tu_vector_is_valid           <= 1'b0;
            o_tu_receiver_ready_for_result <= 1'b1;
            state                          <= WAIT_RESULT;
`ifdef TENSOR_ARB_TIMEOUT_EN
            wait_cnt                       <= '0;
`endif
          end
        end
        WAIT_RESULT: begin
          if (i_tu_result_is_valid && i_tu_this_is_the_last_result) begin
            o_result                       <= i_tu_result;
            o_result_id                    <= job_id;
            o_result_valid                 <= 1'b1;
            o_tu_receiver_ready_for_result <= 1'b0;
            state                          <= DELIVER;
          end
`ifdef TENSOR_ARB_TIMEOUT_EN
          else if (wait_cnt == CNT_LAST) begin
            o_result                       <= '0;
            o_result_id                    <= job_id;
            o_result_error                 <= 1'b1;
            o_result_valid                 <= 1'b1;
            o_tu_receiver_ready_for_result <= 1'b0;
            state                          <= DELIVER;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end
        DELIVER: begin
          if (i_result_ready) begin
            o_result_valid <= 1'b0;
            o_busy         <= 1'b0;
            state          <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tensor_job_arbiter.sv
// tb_tensor_job_arbiter: directed scenarios plus randomized traffic, with a
// job-level reference model compared against the DUT every cycle.
// Watchdog scenario follows TENSOR_ARB_TIMEOUT_EN.
module tb_tensor_job_arbiter;

  localparam int DW = 32;
  localparam int MS = 4;
  localparam int TO = 16;
  localparam int MW = DW * MS * MS;
  localparam int VW = DW * MS;

  logic          aclk = 1'b0;
  logic          areset;
  logic [1:0]    i_req_valid;
  logic [1:0]    o_req_ready;
  logic [MW-1:0] i_req0_matrix, i_req1_matrix;
  logic [VW-1:0] i_req0_vector, i_req1_vector;
  logic [MW-1:0] o_tu_matrix;
  logic [VW-1:0] o_tu_vector;
  logic          o_tu_matrix_is_valid, o_tu_vector_is_valid;
  logic          i_tu_ready_to_accept_matrix, i_tu_ready_to_accept_vector;
  logic          o_tu_receiver_ready_for_result;
  logic          i_tu_result_is_valid, i_tu_this_is_the_last_result;
  logic [VW-1:0] i_tu_result;
  logic [VW-1:0] o_result;
  logic          o_result_id, o_result_error, o_result_valid;
  logic          i_result_ready;
  logic          o_busy;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;
  logic [1:0] acc;

  // Reference model: job-level view of the arbiter
  bit          m_busy, m_offer, m_wait, m_deliver, m_ptr, m_id;
  logic [MW-1:0] m_mat;
  logic [VW-1:0] m_vec, m_res;
  bit          m_res_id, m_err;
  int          m_cnt;
  int          deliveries = 0;
  bit          m_g;

  tensor_job_arbiter #(.D_WIDTH(DW), .M_SIZE(MS), .TIMEOUT_CYCLES(TO)) dut (
    .aclk(aclk), .areset(areset),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req0_matrix(i_req0_matrix), .i_req1_matrix(i_req1_matrix),
    .i_req0_vector(i_req0_vector), .i_req1_vector(i_req1_vector),
    .o_tu_matrix(o_tu_matrix), .o_tu_vector(o_tu_vector),
    .o_tu_matrix_is_valid(o_tu_matrix_is_valid), .o_tu_vector_is_valid(o_tu_vector_is_valid),
    .i_tu_ready_to_accept_matrix(i_tu_ready_to_accept_matrix),
    .i_tu_ready_to_accept_vector(i_tu_ready_to_accept_vector),
    .o_tu_receiver_ready_for_result(o_tu_receiver_ready_for_result),
    .i_tu_result_is_valid(i_tu_result_is_valid),
    .i_tu_this_is_the_last_result(i_tu_this_is_the_last_result),
    .i_tu_result(i_tu_result),
    .o_result(o_result), .o_result_id(o_result_id), .o_result_error(o_result_error),
    .o_result_valid(o_result_valid), .i_result_ready(i_result_ready),
    .o_busy(o_busy)
  );

  // Free-running clock
  always #5 aclk = ~aclk;

  task automatic checkOutput(input string name, input logic [MW-1:0] act, input logic [MW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [MW-1:0] randMat();
    logic [MW-1:0] r;
    for (int j = 0; j < MS * MS; j++) r[j*DW +: DW] = $urandom();
    return r;
  endfunction

  function automatic logic [VW-1:0] randVec();
    logic [VW-1:0] r;
    for (int j = 0; j < MS; j++) r[j*DW +: DW] = $urandom();
    return r;
  endfunction

  // Advance the reference model on every rising edge using the sampled inputs
  always @(posedge aclk) begin
    if (areset) begin
      m_busy = 0; m_offer = 0; m_wait = 0; m_deliver = 0; m_ptr = 0; m_id = 0;
      m_mat = '0; m_vec = '0; m_res = '0; m_res_id = 0; m_err = 0; m_cnt = 0;
    end else if (!m_busy) begin
      if (i_req_valid != 2'b00) begin
        m_g = i_req_valid[m_ptr] ? m_ptr : !m_ptr;
        m_mat = m_g ? i_req1_matrix : i_req0_matrix;
        m_vec = m_g ? i_req1_vector : i_req0_vector;
        m_id = m_g;
        m_ptr = !m_g;
        m_busy = 1;
        m_offer = 1;
`ifdef TENSOR_ARB_TIMEOUT_EN
        m_err = 0;
`endif
      end
    end else if (m_offer) begin
      if (i_tu_ready_to_accept_matrix && i_tu_ready_to_accept_vector) begin
        m_offer = 0;
        m_wait = 1;
        m_cnt = 0;
      end
    end else if (m_wait) begin
      if (i_tu_result_is_valid && i_tu_this_is_the_last_result) begin
        m_res = i_tu_result;
        m_res_id = m_id;
        m_wait = 0;
        m_deliver = 1;
      end else begin
        m_cnt++;
`ifdef TENSOR_ARB_TIMEOUT_EN
        if (m_cnt == TO) begin
          m_res = '0;
          m_res_id = m_id;
          m_err = 1;
          m_wait = 0;
          m_deliver = 1;
        end
`endif
      end
    end else if (m_deliver && i_result_ready) begin
      m_deliver = 0;
      m_busy = 0;
      deliveries++;
    end
  end

  // Compare every DUT output against the model away from the active edge
  always @(negedge aclk) begin
    logic [1:0] exp_rdy;
    if (cmp_en) begin
      exp_rdy = 2'b00;
      if (!m_busy && !areset) begin
        if (i_req_valid[m_ptr]) exp_rdy[m_ptr] = 1'b1;
        else if (i_req_valid[!m_ptr]) exp_rdy[!m_ptr] = 1'b1;
      end
      checkOutput("req_ready", o_req_ready, exp_rdy);
      checkOutput("tu_mat_valid", o_tu_matrix_is_valid, m_offer);
      checkOutput("tu_vec_valid", o_tu_vector_is_valid, m_offer);
      checkOutput("tu_matrix", o_tu_matrix, m_mat);
      checkOutput("tu_vector", o_tu_vector, m_vec);
      checkOutput("tu_rx_ready", o_tu_receiver_ready_for_result, m_wait);
      checkOutput("result_valid", o_result_valid, m_deliver);
      checkOutput("result", o_result, m_res);
      checkOutput("result_id", o_result_id, m_res_id);
      checkOutput("result_error", o_result_error, m_err);
      checkOutput("busy", o_busy, m_busy);
    end
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic doReset();
    areset = 1'b1;
    i_req_valid = 2'b00;
    tick();
    tick();
    areset = 1'b0;
  endtask

  task automatic acceptJob(input int k, input logic [MW-1:0] m, input logic [VW-1:0] v);
    if (k == 0) begin i_req0_matrix = m; i_req0_vector = v; end
    else begin i_req1_matrix = m; i_req1_vector = v; end
    i_req_valid[k] = 1'b1;
    tick();
    i_req_valid[k] = 1'b0;
  endtask

  task automatic doTransfer();
    i_tu_ready_to_accept_matrix = 1'b1;
    i_tu_ready_to_accept_vector = 1'b1;
    tick();
    i_tu_ready_to_accept_matrix = 1'b0;
    i_tu_ready_to_accept_vector = 1'b0;
  endtask

  task automatic returnResult(input logic [VW-1:0] r);
    i_tu_result_is_valid = 1'b1;
    i_tu_this_is_the_last_result = 1'b1;
    i_tu_result = r;
    tick();
    i_tu_result_is_valid = 1'b0;
    i_tu_this_is_the_last_result = 1'b0;
  endtask

  task automatic drain();
    i_result_ready = 1'b1;
    tick();
    i_result_ready = 1'b0;
  endtask

  // One randomized cycle: requesters hold valid/data until accepted
  task automatic applyStimulus();
    for (int k = 0; k < 2; k++) begin
      if (acc[k]) begin
        i_req_valid[k] = 1'b0;
      end else if (!i_req_valid[k] && $urandom_range(0, 3) == 0) begin
        if (k == 0) begin i_req0_matrix = randMat(); i_req0_vector = randVec(); end
        else begin i_req1_matrix = randMat(); i_req1_vector = randVec(); end
        i_req_valid[k] = 1'b1;
      end
    end
    i_tu_ready_to_accept_matrix  = ($urandom_range(0, 2) != 0);
    i_tu_ready_to_accept_vector  = ($urandom_range(0, 2) != 0);
    i_tu_result_is_valid         = ($urandom_range(0, 1) == 1);
    i_tu_this_is_the_last_result = ($urandom_range(0, 3) == 0);
    i_tu_result                  = randVec();
    i_result_ready               = ($urandom_range(0, 2) == 0);
    areset                       = ($urandom_range(0, 199) == 0);
    @(negedge aclk);
    acc = i_req_valid & o_req_ready & {2{!areset}};
    @(posedge aclk);
    #1;
  endtask

  initial begin
    logic [MW-1:0] ident, m;
    logic [VW-1:0] v14, v5678, v, r;
    int d0;

    ident = '0;
    for (int i = 0; i < MS; i++) ident[(i*MS+i)*DW +: DW] = 32'h3F800000;
    v14   = {32'h40800000, 32'h40400000, 32'h40000000, 32'h3F800000};
    v5678 = {32'h41000000, 32'h40E00000, 32'h40C00000, 32'h40A00000};

    areset = 1'b1;
    i_req_valid = 2'b00;
    i_req0_matrix = '0; i_req1_matrix = '0;
    i_req0_vector = '0; i_req1_vector = '0;
    i_tu_ready_to_accept_matrix = 1'b0;
    i_tu_ready_to_accept_vector = 1'b0;
    i_tu_result_is_valid = 1'b0;
    i_tu_this_is_the_last_result = 1'b0;
    i_tu_result = '0;
    i_result_ready = 1'b0;
    acc = 2'b00;
    tick();
    cmp_en = 1'b1;
    tick();
    checkOutput("reset_busy", o_busy, 1'b0);
    checkOutput("reset_result_valid", o_result_valid, 1'b0);
    checkOutput("reset_tu_valid", o_tu_matrix_is_valid, 1'b0);
    areset = 1'b0;

    $display("[TB] identity job from requester 0");
    i_req0_matrix = ident;
    i_req0_vector = v14;
    i_req_valid = 2'b01;
    #1;
    checkOutput("t1_ready", o_req_ready, 2'b01);
    tick();
    i_req_valid = 2'b00;
    checkOutput("t1_tu_valid", o_tu_matrix_is_valid, 1'b1);
    checkOutput("t1_tu_matrix", o_tu_matrix, ident);
    checkOutput("t1_tu_vector", o_tu_vector, v14);
    doTransfer();
    checkOutput("t1_tu_valid_drop", o_tu_vector_is_valid, 1'b0);
    returnResult(v14);
    checkOutput("t1_result", o_result, v14);
    checkOutput("t1_id", o_result_id, 1'b0);
    repeat (3) tick();
    checkOutput("t1_valid_held", o_result_valid, 1'b1);
    drain();
    checkOutput("t1_valid_drop", o_result_valid, 1'b0);
    checkOutput("t1_result_kept", o_result, v14);

    $display("[TB] simultaneous requests alternate");
    doReset();
    for (int j = 0; j < 3; j++) begin
      i_req0_matrix = randMat(); i_req0_vector = randVec();
      if (j == 0) begin i_req1_matrix = randMat(); i_req1_vector = randVec(); end
      i_req_valid = 2'b11;
      #1;
      checkOutput("t2_grant", o_req_ready, (j % 2 == 1) ? 2'b10 : 2'b01);
      tick();
      if (j % 2 == 1) i_req_valid[1] = 1'b0;
      else i_req_valid[0] = 1'b0;
      if (j == 2) i_req_valid = 2'b00;
      doTransfer();
      returnResult(randVec());
      checkOutput("t2_id", o_result_id, (j % 2 == 1) ? 1'b1 : 1'b0);
      drain();
    end

    $display("[TB] backpressure on both sides");
    m = randMat(); v = randVec(); r = randVec();
    acceptJob(0, m, v);
    repeat (5) tick();
    checkOutput("t3_tu_valid_held", o_tu_matrix_is_valid, 1'b1);
    checkOutput("t3_tu_matrix_held", o_tu_matrix, m);
    checkOutput("t3_tu_vector_held", o_tu_vector, v);
    doTransfer();
    d0 = deliveries;
    returnResult(r);
    repeat (10) tick();
    checkOutput("t3_result_held", o_result, r);
    checkOutput("t3_valid_held", o_result_valid, 1'b1);
    drain();
    tick();
    checkOutput("t3_deliveries", 32'(deliveries - d0), 32'd1);

    $display("[TB] only the last beat is captured");
    acceptJob(1, randMat(), randVec());
    doTransfer();
    for (int j = 0; j < 3; j++) begin
      i_tu_result_is_valid = 1'b1;
      i_tu_this_is_the_last_result = 1'b0;
      i_tu_result = randVec();
      tick();
    end
    checkOutput("t4_not_yet", o_result_valid, 1'b0);
    returnResult(v5678);
    checkOutput("t4_result", o_result, v5678);
    checkOutput("t4_id", o_result_id, 1'b1);
    drain();

    $display("[TB] reset while waiting for a result");
    acceptJob(0, randMat(), randVec());
    doTransfer();
    d0 = deliveries;
    areset = 1'b1;
    tick();
    areset = 1'b0;
    checkOutput("t5_busy", o_busy, 1'b0);
    checkOutput("t5_rx_ready", o_tu_receiver_ready_for_result, 1'b0);
    checkOutput("t5_result", o_result, '0);
    checkOutput("t5_tu_matrix", o_tu_matrix, '0);
    repeat (2) tick();
    checkOutput("t5_no_delivery", 32'(deliveries - d0), 32'd0);
    i_req1_matrix = randMat(); i_req1_vector = randVec();
    i_req_valid = 2'b10;
    #1;
    checkOutput("t5_ready", o_req_ready, 2'b10);
    tick();
    i_req_valid = 2'b00;
    doTransfer();
    returnResult(v14);
    checkOutput("t5_result_after", o_result, v14);
    drain();

`ifdef TENSOR_ARB_TIMEOUT_EN
    $display("[TB] watchdog expiry");
    acceptJob(0, randMat(), randVec());
    doTransfer();
    repeat (TO - 1) tick();
    checkOutput("t6_early", o_result_valid, 1'b0);
    tick();
    checkOutput("t6_valid", o_result_valid, 1'b1);
    checkOutput("t6_error", o_result_error, 1'b1);
    checkOutput("t6_result", o_result, '0);
    drain();
    acceptJob(1, randMat(), randVec());
    checkOutput("t6_error_cleared", o_result_error, 1'b0);
    doTransfer();
    returnResult(v5678);
    drain();
`else
    $display("[TB] no watchdog: wait indefinitely");
    acceptJob(0, randMat(), randVec());
    doTransfer();
    repeat (1000) tick();
    checkOutput("t6_still_busy", o_busy, 1'b1);
    checkOutput("t6_no_result", o_result_valid, 1'b0);
    checkOutput("t6_no_error", o_result_error, 1'b0);
    doReset();
`endif

    $display("[TB] randomized traffic");
    acc = 2'b00;
    for (int c = 0; c < 3000; c++) applyStimulus();
    areset = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tensor_job_arbiter.md
Name: tensor_job_arbiter

Overview:
Shares one TensorUnit matrix-vector multiplier between two requesters. Each job is a full matrix plus a vector of IEEE-754 float32 words. The block arbitrates between the requesters round-robin, latches the winning job, and drives the TensorUnit valid/ready handshake. It then captures the last result beat and returns the result, tagged with the requester ID, through a valid/ready output port.

Parameters:
- D_WIDTH, 32, element width in bits (float32).
- M_SIZE, 4, matrix dimension; the matrix is M_SIZE x M_SIZE and the vector is M_SIZE x 1.
- TIMEOUT_CYCLES, 256, watchdog limit in cycles. Used only with TENSOR_ARB_TIMEOUT_EN.

Ports:
- aclk  in  1  clock; all logic on the rising edge.
- areset  in  1  reset, synchronous, active-high.
- i_req_valid  in  2  per-requester job valid; bit k belongs to requester k.
- o_req_ready  out  2  per-requester accept.
- i_req0_matrix / i_req1_matrix  in  D_WIDTH*M_SIZE*M_SIZE  job matrix.
- i_req0_vector / i_req1_vector  in  D_WIDTH*M_SIZE  job vector.
- o_tu_matrix  out  D_WIDTH*M_SIZE*M_SIZE  to TensorUnit i_matrix.
- o_tu_vector  out  D_WIDTH*M_SIZE  to TensorUnit i_vector.
- o_tu_matrix_is_valid, o_tu_vector_is_valid  out  1 each  to TensorUnit.
- i_tu_ready_to_accept_matrix, i_tu_ready_to_accept_vector  in  1 each  from TensorUnit.
- o_tu_receiver_ready_for_result  out  1  to TensorUnit.
- i_tu_result_is_valid, i_tu_this_is_the_last_result  in  1 each  from TensorUnit.
- i_tu_result  in  D_WIDTH*M_SIZE  from TensorUnit.
- o_result  out  D_WIDTH*M_SIZE  delivered result.
- o_result_id  out  1  requester that owns o_result.
- o_result_error  out  1  result is invalid (timeout).
- o_result_valid  out  1  result available.
- i_result_ready  in  1  consumer accepts the result.
- o_busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (areset high at an edge):
  - State goes to IDLE.
  - All outputs are 0: o_req_ready, o_tu_*, o_result*, o_busy.
  - Priority pointer set to requester 0.
  - A job in flight is discarded. TensorUnit shares the same reset.
- FSM states: IDLE -> ISSUE -> WAIT_RESULT -> DELIVER -> IDLE.
- IDLE:
  - o_req_ready is combinational and one-hot: bit g is set, where g is the grant winner among valid requesters.
  - Grant rule: the pointer requester wins if valid, otherwise the other requester.
  - Accept happens at the edge where i_req_valid[g] & o_req_ready[g]. At that edge: latch matrix and vector into internal registers, latch the ID, set pointer to ~g, go to ISSUE.
  - No request: stay in IDLE.
- ISSUE:
  - o_tu_matrix_is_valid and o_tu_vector_is_valid are both 1. o_tu_matrix and o_tu_vector come from the latched copy and stay stable.
  - First valid cycle is the cycle after accept (1-cycle latency).
  - Transfer happens at an edge where both TensorUnit readies are 1 in the same cycle. Valids drop the next cycle; go to WAIT_RESULT.
  - If only one ready is high, hold and keep waiting.
- WAIT_RESULT:
  - o_tu_receiver_ready_for_result = 1.
  - At an edge where i_tu_result_is_valid & i_tu_this_is_the_last_result: capture i_tu_result into o_result, go to DELIVER.
  - Valid beats without last are ignored.
- DELIVER:
  - o_result_valid = 1; o_result and o_result_id are held stable.
  - At an edge where i_result_ready is high: return to IDLE. o_result_valid drops; o_result keeps its value.
  - A new accept is possible in the cycle after delivery completes.
- Requests arriving while busy are not accepted; o_req_ready stays 0. Requesters must hold valid and data until accepted.
- Simultaneous requests: grants strictly alternate between the two requesters.
- No arithmetic is performed; widths pass through unchanged.

Optional Feature:
Macro TENSOR_ARB_TIMEOUT_EN.
- Defined:
  - A counter of width clog2(TIMEOUT_CYCLES+1) clears on entry to WAIT_RESULT and increments each cycle spent there.
  - When it reaches TIMEOUT_CYCLES with no last beat: go to DELIVER with o_result = 0 and o_result_error = 1.
  - o_result_error clears on the next accept.
- Not defined: no counter; o_result_error is tied to 0; WAIT_RESULT waits indefinitely.

Test Plan:
1. Requester 0 submits a 4x4 identity matrix (diagonal 0x3F800000) and vector {1.0, 2.0, 3.0, 4.0} (0x3F800000, 0x40000000, 0x40400000, 0x40800000) -> o_tu valids rise 1 cycle after accept. o_result equals the input vector, o_result_id = 0, o_result_valid held until i_result_ready.
2. Both requesters valid in the same cycle after reset, repeated for 3 jobs -> grant order 0, 1, 0; o_result_id sequence 0, 1, 0; o_req_ready never has 2 bits set.
3. Backpressure: TensorUnit readies held low for 5 cycles, then i_result_ready held low for 10 cycles -> valids and o_tu data stable throughout; o_result stable; exactly one delivery.
4. TensorUnit emits 3 valid beats without last, then a last beat carrying {5.0, 6.0, 7.0, 8.0} -> only the last beat is captured into o_result.
5. areset asserted for 1 cycle during WAIT_RESULT -> next cycle all outputs are 0, state IDLE, no delivery; a new job afterwards completes normally.
6. With TENSOR_ARB_TIMEOUT_EN and TIMEOUT_CYCLES = 16, TensorUnit never returns -> o_result_valid = 1, o_result_error = 1, o_result = 0 exactly 16 cycles after entering WAIT_RESULT. Without the macro -> still waiting after 1000 cycles.
